// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, decode table and decode function for the seven-segment monitor
package seg7_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } mon_state_t;

  // Active-high blank pattern (all segments off), gfedcba order
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high segment patterns for hex digits 0..F, gfedcba order
  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic       valid;
    logic       blank;
    logic [3:0] digit;
  } seg7_dec_t;

  // Neither valid nor blank means the pattern is undecodable
  function automatic seg7_dec_t seg7_decode(input logic [6:0] pattern);
    seg7_dec_t r;
    r.valid = 1'b0;
    r.blank = (pattern == SEG_BLANK);
    r.digit = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG7_TABLE[i]) begin
        r.valid = 1'b1;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_display_monitor_filter.sv
// rtl/seg7_display_monitor_filter.sv - glitch filter emitting one stable event per held segment pattern
module seg7_stability_filter #(
  parameter int         STABLE_CYCLES = 4,
  parameter logic [6:0] RESET_VAL     = 7'h7F
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] i_seg,
  output logic [6:0] o_seg_q,
  output logic       o_stable
);

  localparam logic [7:0] LIMIT = 8'(STABLE_CYCLES);

  logic [6:0] r_seg_q;
  logic [7:0] r_stab_cnt;

  // Recapture on any change; otherwise count up to the limit and park there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_q    <= RESET_VAL;
      r_stab_cnt <= 8'd0;
    end else if (i_seg != r_seg_q) begin
      r_seg_q    <= i_seg;
      r_stab_cnt <= 8'd0;
    end else if (r_stab_cnt < LIMIT) begin
      r_stab_cnt <= r_stab_cnt + 8'd1;
    end
  end

  // Fires on the edge where the counter would reach the limit; the parked
  // counter cannot match again, so each held pattern yields one event
  assign o_stable = (i_seg == r_seg_q) && (r_stab_cnt == LIMIT - 8'd1);
  assign o_seg_q  = r_seg_q;

endmodule

// File: rtl/seg7_display_monitor.sv
// rtl/seg7_display_monitor.sv - seven-segment sequence monitor; error counter enabled by SEG7_MON_ERRCNT_EN
module seg7_display_monitor
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ERR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             locked,
  output logic             seq_err,
  output logic             pat_err,
  output logic [ERR_W-1:0] err_count
);

  // Filter works in the raw input polarity, so its reset value is blank in that polarity
  localparam logic [6:0] RAW_BLANK = (ACTIVE_LOW_SEG != 0) ? ~SEG_BLANK : SEG_BLANK;

  logic [6:0] w_seg_q;
  logic       w_stable;
  logic [6:0] w_seg_act;
  seg7_dec_t  w_dec;

  mon_state_t r_state, w_state_nxt;
  logic [3:0] r_digit, w_digit_nxt;
  logic       r_dv, r_seq, r_pat;
  logic       w_dv_nxt, w_seq_nxt, w_pat_nxt;

  seg7_stability_filter #(
    .STABLE_CYCLES (STABLE_CYCLES),
    .RESET_VAL     (RAW_BLANK)
  ) u_filter (
    .clk      (clk),
    .rst_n    (reset),
    .i_seg    (seg_in),
    .o_seg_q  (w_seg_q),
    .o_stable (w_stable)
  );

  assign w_seg_act = (ACTIVE_LOW_SEG != 0) ? ~w_seg_q : w_seg_q;
  assign w_dec     = seg7_decode(w_seg_act);

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEARCH;
      r_digit <= 4'd0;
      r_dv    <= 1'b0;
      r_seq   <= 1'b0;
      r_pat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_digit <= w_digit_nxt;
      r_dv    <= w_dv_nxt;
      r_seq   <= w_seq_nxt;
      r_pat   <= w_pat_nxt;
    end
  end

  // Act only on stable events; a repeat of the current digit is a returned glitch
  always_comb begin
    w_state_nxt = r_state;
    w_digit_nxt = r_digit;
    w_dv_nxt    = 1'b0;
    w_seq_nxt   = 1'b0;
    w_pat_nxt   = 1'b0;
    if (w_stable) begin
      case (r_state)
        SEARCH: begin
          if (w_dec.valid) begin
            w_digit_nxt = w_dec.digit;
            w_dv_nxt    = 1'b1;
            w_state_nxt = LOCKED;
          end else if (!w_dec.blank) begin
            w_pat_nxt   = 1'b1;
          end
        end
        LOCKED: begin
          if (w_dec.valid) begin
            if (w_dec.digit != r_digit) begin
              w_digit_nxt = w_dec.digit;
              w_dv_nxt    = 1'b1;
              w_seq_nxt   = (w_dec.digit != r_digit + 4'd1);
            end
          end else if (w_dec.blank) begin
            w_state_nxt = SEARCH;
          end else begin
            w_pat_nxt   = 1'b1;
            w_state_nxt = SEARCH;
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

`ifdef SEG7_MON_ERRCNT_EN
  logic [ERR_W-1:0] r_err_count;
  logic             w_err_inc;

  assign w_err_inc = w_seq_nxt | w_pat_nxt;

  // Saturating error counter; at most one increment per stable event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= '0;
    end else if (w_err_inc && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = '0;
`endif

  assign digit_out   = r_digit;
  assign digit_valid = r_dv;
  assign seq_err     = r_seq;
  assign pat_err     = r_pat;
  assign locked      = (r_state == LOCKED);

endmodule
